// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single-ported, multi-cycle unified memory between instruction
//   fetch (I-side, read-only) and the memory stage (D-side, read/write).
//   One transaction is in flight at a time. D-side has priority, but after
//   MAX_WAIT consecutive D grants with fetch waiting, fetch is forced to win.
// Ports
//   clk, rst (async, active-low), halt (blocks new grants)
//   i_req/i_addr -> i_done/i_rdata/i_stall          fetch port
//   d_req/d_wr/d_addr/d_wdata -> d_done/d_rdata/d_err/d_stall   data port
//   mem_req/mem_wr/mem_addr/mem_wdata, mem_ready/mem_rvalid/mem_rdata  memory
module mem_port_arbiter #(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16,
  parameter int unsigned MAX_WAIT    = 3,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic          own;        // 0 = I-side owns the transaction, 1 = D-side
  logic          wr_r;
  logic          err_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] i_rdata_r;
  logic [DW-1:0] d_rdata_r;
  logic [CW-1:0] wait_cnt;

  logic i_forced, grant_d, grant_i, misalign;

  // Fetch overrides D priority once it has waited through MAX_WAIT D grants.
  always_comb begin
    i_forced = i_req && (wait_cnt == WMAX);
    grant_d  = (state == IDLE) && !halt && d_req && !i_forced;
    grant_i  = (state == IDLE) && !halt && i_req && !grant_d;
    misalign = (ALIGN_CHECK != 0) && d_addr[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_nx = misalign ? RESP : ISSUE;
        else if (grant_i) state_nx = ISSUE;
      end
      ISSUE: if (mem_ready)  state_nx = WAIT;
      WAIT:  if (mem_rvalid) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own       <= 1'b0;
      wr_r      <= 1'b0;
      err_r     <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      i_rdata_r <= '0;
      d_rdata_r <= '0;
      wait_cnt  <= '0;
    end else begin
      if (grant_d) begin
        own     <= 1'b1;
        wr_r    <= d_wr;
        err_r   <= misalign;
        addr_r  <= d_addr;
        wdata_r <= d_wdata;
        if (i_req && wait_cnt != WMAX) wait_cnt <= wait_cnt + 1'b1;
      end else if (grant_i) begin
        own      <= 1'b0;
        wr_r     <= 1'b0;
        err_r    <= 1'b0;
        addr_r   <= i_addr;
        wait_cnt <= '0;
      end
      // Write acks leave d_rdata untouched; only loads update it.
      if (state == WAIT && mem_rvalid) begin
        if (!own)      i_rdata_r <= mem_rdata;
        else if (!wr_r) d_rdata_r <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_req   = (state == ISSUE);
    mem_wr    = mem_req && wr_r;
    mem_addr  = addr_r;
    mem_wdata = wdata_r;
    i_done    = (state == RESP) && !own;
    d_done    = (state == RESP) && own;
    d_err     = d_done && err_r;
    i_rdata   = i_rdata_r;
    d_rdata   = d_rdata_r;
    i_stall   = i_req && !i_done;
    d_stall   = d_req && !d_done;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A small memory responder raises
// mem_ready after rdy_delay cycles of mem_req and returns mem_rvalid the
// following cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        i_stall;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        d_err;
  logic        d_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  int          rdy_delay;
  int          rdy_cnt;
  logic        rv_pend;
  logic [15:0] mem_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(16), .MAX_WAIT(3), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err), .d_stall(d_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic drive_mem();
    mem_rvalid = rv_pend;
    mem_rdata  = rv_pend ? mem_resp : 16'h0000;
    rv_pend    = 1'b0;
    mem_ready  = 1'b0;
    if (mem_req) begin
      if (rdy_cnt >= rdy_delay) begin
        mem_ready = 1'b1;
        rv_pend   = 1'b1;
        rdy_cnt   = 0;
      end else begin
        rdy_cnt++;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; halt = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rv_pend = 1'b0; rdy_cnt = 0; rdy_delay = 0; mem_resp = '0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; halt = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 16'h1111; d_addr = 16'h2222; d_wdata = 16'h3333;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
    rv_pend = 1'b0; rdy_cnt = 0; rdy_delay = 0;
    next_cycle();
    next_cycle();
    if ({mem_req, mem_wr, i_done, d_done, d_err, i_stall, d_stall} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000000",
                      {mem_req, mem_wr, i_done, d_done, d_err, i_stall, d_stall});
    end
    total++;
    if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {i_rdata, d_rdata, mem_addr, mem_wdata});
    end
    total++;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_single_fetch();
    int done_at = -1;
    int stall_cnt = 0;
    int addr_bad = 0;
    do_reset();
    mem_resp = 16'h1234; rdy_delay = 0;
    i_req = 1'b1; i_addr = 16'h0010;
    for (int c = 0; c < 12 && done_at < 0; c++) begin
      drive_mem();
      #1;
      if (mem_req && (mem_addr !== 16'h0010 || mem_wr !== 1'b0)) addr_bad++;
      if (i_stall) stall_cnt++;
      if (i_done) done_at = c;
      next_cycle();
    end
    if (done_at !== 3) begin
      bad++; $display("FAIL fetch_latency got=%0d exp=3", done_at);
    end
    total++;
    if (i_rdata !== 16'h1234) begin
      bad++; $display("FAIL fetch_rdata got=%h exp=1234", i_rdata);
    end
    total++;
    if (stall_cnt !== 3) begin
      bad++; $display("FAIL fetch_stall_cycles got=%0d exp=3", stall_cnt);
    end
    total++;
    if (addr_bad !== 0) begin
      bad++; $display("FAIL fetch_issue_fields got=%0d exp=0", addr_bad);
    end
    total++;
    i_req = 1'b0;
    drive_mem();
    #1;
    if (i_done !== 1'b0) begin
      bad++; $display("FAIL fetch_done_pulse got=%b exp=0", i_done);
    end
    total++;
  endtask

  task automatic test_starvation();
    logic [7:0] seq [5];
    logic [7:0] exp_seq [5];
    int n = 0;
    int field_bad = 0;
    do_reset();
    exp_seq[0] = "D"; exp_seq[1] = "D"; exp_seq[2] = "D"; exp_seq[3] = "I"; exp_seq[4] = "D";
    mem_resp = 16'h0F0F; rdy_delay = 0;
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
    for (int c = 0; c < 80 && n < 5; c++) begin
      drive_mem();
      #1;
      if (mem_req && mem_wr && (mem_wdata !== 16'hBEEF || mem_addr !== 16'h0020)) field_bad++;
      if (mem_req && !mem_wr && mem_addr !== 16'h0010) field_bad++;
      if (i_done && d_done) field_bad++;
      if (i_done) begin seq[n] = "I"; n++; end
      else if (d_done) begin seq[n] = "D"; n++; end
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    if (n !== 5) begin
      bad++; $display("FAIL grant_count got=%0d exp=5", n);
    end
    total++;
    for (int k = 0; k < 5; k++) begin
      if (k < n && seq[k] !== exp_seq[k]) begin
        bad++; $display("FAIL grant_order[%0d] got=%s exp=%s", k, seq[k], exp_seq[k]);
      end
      total++;
    end
    if (field_bad !== 0) begin
      bad++; $display("FAIL store_issue_fields got=%0d exp=0", field_bad);
    end
    total++;
    if (d_rdata !== 16'h0000) begin
      bad++; $display("FAIL write_keeps_d_rdata got=%h exp=0000", d_rdata);
    end
    total++;
    if (i_rdata !== 16'h0F0F) begin
      bad++; $display("FAIL fetch_between_stores got=%h exp=0f0f", i_rdata);
    end
    total++;
  endtask

  task automatic test_misaligned();
    int done_at = -1;
    int req_seen = 0;
    logic err_at_done = 1'b0;
    do_reset();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0021;
    for (int c = 0; c < 6; c++) begin
      drive_mem();
      #1;
      if (mem_req) req_seen++;
      if (d_done && done_at < 0) begin done_at = c; err_at_done = d_err; d_req = 1'b0; end
      next_cycle();
    end
    if (done_at !== 1) begin
      bad++; $display("FAIL misalign_latency got=%0d exp=1", done_at);
    end
    total++;
    if (err_at_done !== 1'b1) begin
      bad++; $display("FAIL misalign_err got=%b exp=1", err_at_done);
    end
    total++;
    if (req_seen !== 0) begin
      bad++; $display("FAIL misalign_no_mem got=%0d exp=0", req_seen);
    end
    total++;
    if (d_err !== 1'b0 || d_done !== 1'b0) begin
      bad++; $display("FAIL misalign_pulse got=%b%b exp=00", d_done, d_err);
    end
    total++;
  endtask

  task automatic test_halt();
    int done_at = -1;
    int late_req = 0;
    int i_done_cnt = 0;
    do_reset();
    mem_resp = 16'h5A5A; rdy_delay = 0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0030;
    i_req = 1'b1; i_addr = 16'h0040;
    for (int c = 0; c < 14; c++) begin
      if (c == 2) halt = 1'b1;
      drive_mem();
      #1;
      if (c > 3 && mem_req) late_req++;
      if (i_done) i_done_cnt++;
      if (d_done && done_at < 0) done_at = c;
      next_cycle();
      if (done_at >= 0) d_req = 1'b0;
    end
    if (done_at !== 3) begin
      bad++; $display("FAIL halt_inflight_done got=%0d exp=3", done_at);
    end
    total++;
    if (d_rdata !== 16'h5A5A) begin
      bad++; $display("FAIL halt_d_rdata got=%h exp=5a5a", d_rdata);
    end
    total++;
    if (late_req !== 0 || i_done_cnt !== 0) begin
      bad++; $display("FAIL halt_blocks_grant got=%0d/%0d exp=0/0", late_req, i_done_cnt);
    end
    total++;
    halt = 1'b0; i_req = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int done_at = -1;
    int stale_done = 0;
    do_reset();
    mem_resp = 16'h7777; rdy_delay = 0;
    i_req = 1'b1; i_addr = 16'h0040;
    drive_mem(); next_cycle();          // grant
    drive_mem(); next_cycle();          // issue with ready -> WAIT
    mem_ready = 1'b0; mem_rvalid = 1'b0; rv_pend = 1'b0;
    #1 rst = 1'b0;
    #1;
    if ({mem_req, i_done, d_done, mem_addr} !== 19'h0) begin
      bad++; $display("FAIL async_reset_outputs got=%h exp=0", {mem_req, i_done, d_done, mem_addr});
    end
    total++;
    i_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (i_done || d_done) stale_done++;
      next_cycle();
      mem_rvalid = 1'b0;
    end
    if (stale_done !== 0 || i_rdata !== 16'h0000) begin
      bad++; $display("FAIL stale_rvalid got=%0d/%h exp=0/0000", stale_done, i_rdata);
    end
    total++;
    mem_resp = 16'h4321; i_req = 1'b1; i_addr = 16'h0050;
    for (int c = 0; c < 12 && done_at < 0; c++) begin
      drive_mem();
      #1;
      if (i_done) done_at = c;
      next_cycle();
    end
    i_req = 1'b0;
    if (done_at !== 3 || i_rdata !== 16'h4321) begin
      bad++; $display("FAIL fetch_after_reset got=%0d/%h exp=3/4321", done_at, i_rdata);
    end
    total++;
  endtask

  task automatic test_slow_ready();
    int done_at = -1;
    int req_cycles = 0;
    int unstable = 0;
    do_reset();
    mem_resp = 16'h2468; rdy_delay = 5;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0060;
    for (int c = 0; c < 20 && done_at < 0; c++) begin
      drive_mem();
      #1;
      if (mem_req) begin
        req_cycles++;
        if (mem_addr !== 16'h0060 || mem_wr !== 1'b0) unstable++;
      end
      if (d_done) done_at = c;
      next_cycle();
    end
    d_req = 1'b0;
    if (req_cycles !== 6) begin
      bad++; $display("FAIL slow_req_cycles got=%0d exp=6", req_cycles);
    end
    total++;
    if (unstable !== 0) begin
      bad++; $display("FAIL slow_req_stable got=%0d exp=0", unstable);
    end
    total++;
    if (done_at !== 8 || d_rdata !== 16'h2468) begin
      bad++; $display("FAIL slow_done got=%0d/%h exp=8/2468", done_at, d_rdata);
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_starvation();
    test_misaligned();
    test_halt();
    test_reset_in_wait();
    test_slow_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
